// File: rtl/shift_register_pe.sv
// N-bit register with preset, parallel load and multi-cycle shift-by-N under a busy/done FSM.
// Define SHIFT_REG_ROTATE_EN to turn mode 11 into rotate-left instead of arithmetic right shift.
module shift_register_pe #(
    parameter int               WIDTH        = 8,
    parameter int               SHIFT_BITS   = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter logic [WIDTH-1:0] PRESET_VALUE = '1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  input_preset,
    input  logic                  input_clock_enable,
    input  logic                  input_start,
    input  logic [1:0]            input_mode,
    input  logic [SHIFT_BITS-1:0] input_amount,
    input  logic                  input_serial,
    input  logic [WIDTH-1:0]      input_d,
    output logic [WIDTH-1:0]      output_q,
    output logic                  output_serial,
    output logic                  output_busy,
    output logic                  output_done
);

    localparam logic [1:0] MODE_LOAD = 2'b00;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      q_q, q_d;
    logic                  serial_q, serial_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [1:0]            mode_q, mode_d;
    logic                  ser_in_q, ser_in_d;
    logic [SHIFT_BITS-1:0] rem_q, rem_d;

    logic [1:0]            cmd_mode;
    logic                  cmd_ser;
    logic [WIDTH:0]        shifted;

    // Single shift step; result is {bit shifted out, new register value}.
    function automatic logic [WIDTH:0] shift_once(input logic [WIDTH-1:0] v,
                                                  input logic [1:0] mode,
                                                  input logic sin);
        case (mode)
            2'b01:   shift_once = {v[WIDTH-1], v[WIDTH-2:0], sin};
            2'b10:   shift_once = {v[0], sin, v[WIDTH-1:1]};
`ifdef SHIFT_REG_ROTATE_EN
            2'b11:   shift_once = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
`else
            2'b11:   shift_once = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
`endif
            default: shift_once = {1'b0, v};
        endcase
    endfunction

    // The first shift happens on the accepting edge, so IDLE uses the live command inputs.
    assign cmd_mode = (state_q == IDLE) ? input_mode   : mode_q;
    assign cmd_ser  = (state_q == IDLE) ? input_serial : ser_in_q;
    assign shifted  = shift_once(q_q, cmd_mode, cmd_ser);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            q_q      <= RESET_VALUE;
            serial_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mode_q   <= MODE_LOAD;
            ser_in_q <= 1'b0;
            rem_q    <= '0;
        end else if (input_preset) begin
            state_q  <= IDLE;
            q_q      <= PRESET_VALUE;
            serial_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mode_q   <= MODE_LOAD;
            ser_in_q <= 1'b0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mode_q   <= mode_d;
            ser_in_q <= ser_in_d;
            rem_q    <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (input_clock_enable) begin
            case (state_q)
                IDLE:    if (input_start && input_mode != MODE_LOAD &&
                             input_amount > SHIFT_BITS'(1)) state_d = SHIFT;
                SHIFT:   if (rem_q == SHIFT_BITS'(1)) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // done defaults low so it is a single-clock pulse even while enable is low.
    always_comb begin
        q_d      = q_q;
        serial_d = serial_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        mode_d   = mode_q;
        ser_in_d = ser_in_q;
        rem_d    = rem_q;
        if (input_clock_enable) begin
            if (state_q == IDLE) begin
                if (input_start) begin
                    mode_d   = input_mode;
                    ser_in_d = input_serial;
                    rem_d    = '0;
                    if (input_mode == MODE_LOAD) begin
                        q_d    = input_d;
                        done_d = 1'b1;
                    end else if (input_amount == '0) begin
                        done_d = 1'b1;
                    end else begin
                        q_d      = shifted[WIDTH-1:0];
                        serial_d = shifted[WIDTH];
                        rem_d    = input_amount - SHIFT_BITS'(1);
                        if (input_amount == SHIFT_BITS'(1)) done_d = 1'b1;
                        else                               busy_d = 1'b1;
                    end
                end
            end else begin
                q_d      = shifted[WIDTH-1:0];
                serial_d = shifted[WIDTH];
                rem_d    = rem_q - SHIFT_BITS'(1);
                if (rem_q == SHIFT_BITS'(1)) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
        end
    end

    assign output_q      = q_q;
    assign output_serial = serial_q;
    assign output_busy   = busy_q;
    assign output_done   = done_q;

endmodule

// File: tb/tb_shift_register_pe.sv
// Bench for shift_register_pe: directed vector table, hand-written corner sequences, random commands vs model.
// Honours SHIFT_REG_ROTATE_EN the same way as the design.
module tb_shift_register_pe;

    logic       clock = 1'b0;
    logic       reset, input_preset, input_clock_enable, input_start, input_serial;
    logic [1:0] input_mode;
    logic [2:0] input_amount;
    logic [7:0] input_d, output_q;
    logic       output_serial, output_busy, output_done;

    int n_vec = 0;
    int n_bad = 0;

    shift_register_pe #(.WIDTH(8), .SHIFT_BITS(3), .RESET_VALUE(8'h00), .PRESET_VALUE(8'hFF)) dut (
        .clock(clock), .reset(reset), .input_preset(input_preset),
        .input_clock_enable(input_clock_enable), .input_start(input_start),
        .input_mode(input_mode), .input_amount(input_amount), .input_serial(input_serial),
        .input_d(input_d), .output_q(output_q), .output_serial(output_serial),
        .output_busy(output_busy), .output_done(output_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [7:0] init;
        logic [1:0] mode;
        int         amt;
        logic       sin;
        logic [7:0] d;
        logic [7:0] exp_q;
        logic       exp_ser;
    } vec_t;

    vec_t vt[8];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Whole-command result from arithmetic on the starting value: {last bit out, final q}.
    function automatic logic [8:0] model(input logic [1:0] m, input int n, input logic s,
                                         input logic [7:0] d, input logic [7:0] q, input logic ser);
        int qi, r, o;
        qi = int'(q);
        r  = qi;
        o  = int'(ser);
        if (m == 2'b00) r = int'(d);
        else if (n > 0) begin
            case (m)
                2'b01: begin
                    o = (qi >> (8 - n)) & 1;
                    r = ((qi << n) | (s ? ((1 << n) - 1) : 0)) & 255;
                end
                2'b10: begin
                    o = (qi >> (n - 1)) & 1;
                    r = (qi >> n) | (s ? (255 & ~(255 >> n)) : 0);
                end
                default: begin
`ifdef SHIFT_REG_ROTATE_EN
                    o = (qi >> (8 - n)) & 1;
                    r = ((qi << n) | (qi >> (8 - n))) & 255;
`else
                    o = (qi >> (n - 1)) & 1;
                    r = (qi >> n) | (q[7] ? (255 & ~(255 >> n)) : 0);
`endif
                end
            endcase
        end
        return {o[0], r[7:0]};
    endfunction

    task automatic preset_pulse();
        input_preset = 1'b1;
        tick();
        input_preset = 1'b0;
    endtask

    // Issues one command from IDLE and checks busy/done timing; rnd adds enable holes and ignored starts.
    task automatic do_cmd(input logic [1:0] m, input int amt, input logic s, input logic [7:0] d,
                          input bit rnd);
        int  need, got;
        bit  seen;
        need = (m == 2'b00 || amt == 0) ? 1 : amt;
        input_clock_enable = 1'b1;
        input_start = 1'b1; input_mode = m; input_amount = amt[2:0]; input_serial = s; input_d = d;
        tick();
        got  = 1;
        seen = 1'b0;
        input_start = 1'b0;
        for (int w = 0; w < 64; w++) begin
            if (output_done) begin
                seen = 1'b1;
                break;
            end
            check("busy_during_shift", output_busy, 1);
            if (rnd) begin
                input_clock_enable = ($urandom % 4) != 0;
                input_start  = $urandom % 2;
                input_mode   = 2'($urandom);
                input_amount = 3'($urandom);
                input_serial = 1'($urandom);
                input_d      = 8'($urandom);
            end
            tick();
            if (input_clock_enable) got++;
        end
        check("done_seen", seen, 1);
        check("busy_low_at_done", output_busy, 0);
        check("enabled_edges", got, need);
        input_start = 1'b0; input_clock_enable = 1'b1;
        tick();
        check("done_one_cycle", output_done, 0);
    endtask

    initial begin
        logic [8:0] r;
        logic [7:0] mq;
        logic       mser;
        logic [1:0] rm;
        int         ra;
        logic       rs;
        logic [7:0] rd;

        vt[0] = '{"load_a5",   8'h00, 2'b00, 0, 1'b0, 8'hA5, 8'hA5, 1'b0};
        vt[1] = '{"shl3_a5",   8'hA5, 2'b01, 3, 1'b1, 8'h00, 8'h2F, 1'b1};
`ifdef SHIFT_REG_ROTATE_EN
        vt[2] = '{"mode11_84", 8'h84, 2'b11, 2, 1'b1, 8'h00, 8'h12, 1'b0};
        vt[3] = '{"mode11_80", 8'h80, 2'b11, 7, 1'b0, 8'h00, 8'h40, 1'b0};
`else
        vt[2] = '{"mode11_84", 8'h84, 2'b11, 2, 1'b1, 8'h00, 8'hE1, 1'b0};
        vt[3] = '{"mode11_80", 8'h80, 2'b11, 7, 1'b0, 8'h00, 8'hFF, 1'b0};
`endif
        vt[4] = '{"shr4_f0",   8'hF0, 2'b10, 4, 1'b0, 8'h00, 8'h0F, 1'b0};
        vt[5] = '{"shl0_3c",   8'h3C, 2'b01, 0, 1'b1, 8'h00, 8'h3C, 1'b0};
        vt[6] = '{"shr1_81",   8'h81, 2'b10, 1, 1'b1, 8'h00, 8'hC0, 1'b1};
        vt[7] = '{"shl7_01",   8'h01, 2'b01, 7, 1'b0, 8'h00, 8'h80, 1'b0};

        reset = 1'b1; input_preset = 1'b0; input_clock_enable = 1'b0; input_start = 1'b0;
        input_mode = 2'b00; input_amount = 3'd0; input_serial = 1'b0; input_d = 8'h00;
        tick();
        check("reset_q", output_q, 8'h00);
        check("reset_busy", output_busy, 0);
        check("reset_done", output_done, 0);
        check("reset_serial", output_serial, 0);
        reset = 1'b0;
        preset_pulse();
        check("preset_q", output_q, 8'hFF);
        check("preset_busy", output_busy, 0);
        check("preset_done", output_done, 0);

        foreach (vt[i]) begin
            preset_pulse();
            do_cmd(2'b00, 0, 1'b0, vt[i].init, 1'b0);
            do_cmd(vt[i].mode, vt[i].amt, vt[i].sin, vt[i].d, 1'b0);
            check({vt[i].name, "_q"}, output_q, vt[i].exp_q);
            check({vt[i].name, "_serial"}, output_serial, vt[i].exp_ser);
        end

        // Enable dropped for two cycles mid-shift: state holds, done arrives after 6 edges.
        do_cmd(2'b00, 0, 1'b0, 8'hF0, 1'b0);
        input_start = 1'b1; input_mode = 2'b10; input_amount = 3'd4; input_serial = 1'b0;
        tick();
        input_start = 1'b0;
        check("hold_first_q", output_q, 8'h78);
        input_clock_enable = 1'b0;
        tick(); tick();
        check("hold_q", output_q, 8'h78);
        check("hold_busy", output_busy, 1);
        check("hold_done", output_done, 0);
        input_clock_enable = 1'b1;
        tick(); tick();
        check("resume_q", output_q, 8'h1E);
        check("resume_busy", output_busy, 1);
        tick();
        check("resume_final_q", output_q, 8'h0F);
        check("resume_done", output_done, 1);
        check("resume_busy_low", output_busy, 0);

        // done clears after one clock even with enable low.
        input_start = 1'b1; input_mode = 2'b00; input_d = 8'h3C;
        tick();
        input_start = 1'b0; input_clock_enable = 1'b0;
        check("load_en0_done", output_done, 1);
        tick();
        check("en0_done_clear", output_done, 0);
        check("en0_q", output_q, 8'h3C);
        input_clock_enable = 1'b1;

        // Start while busy is ignored; preset then aborts without a done pulse.
        do_cmd(2'b00, 0, 1'b0, 8'h01, 1'b0);
        input_start = 1'b1; input_mode = 2'b01; input_amount = 3'd7; input_serial = 1'b0;
        tick();
        input_mode = 2'b00; input_d = 8'h55;
        tick();
        input_start = 1'b0;
        check("ignored_start_q", output_q, 8'h04);
        check("ignored_start_busy", output_busy, 1);
        input_preset = 1'b1;
        tick();
        input_preset = 1'b0;
        check("abort_q", output_q, 8'hFF);
        check("abort_busy", output_busy, 0);
        check("abort_done", output_done, 0);
        tick();
        check("abort_no_done", output_done, 0);
        check("abort_q_hold", output_q, 8'hFF);

        // Random commands against the whole-command model.
        preset_pulse();
        mq = 8'hFF; mser = 1'b0;
        for (int k = 0; k < 60; k++) begin
            rm = 2'($urandom); ra = int'($urandom_range(0, 7)); rs = 1'($urandom); rd = 8'($urandom);
            do_cmd(rm, ra, rs, rd, 1'b1);
            r = model(rm, ra, rs, rd, mq, mser);
            mq = r[7:0]; mser = r[8];
            check("rand_q", output_q, mq);
            check("rand_serial", output_serial, mser);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_register_pe.md
# shift_register_pe

- Parametrised N-bit register with clock enable and synchronous preset; successor to the single-bit enable/preset flip-flop.
- Adds parallel load and multi-cycle shift-by-N (logical left, logical right, arithmetic right), tracked by a small busy/done state machine.
- Serves as the accumulator and shifter register in the 8-bit CPU datapath.

## Interface

- WIDTH, 8, register width in bits (≥2)
- SHIFT_BITS, 3, width of shift amount field (max shift = 2^SHIFT_BITS−1)
- RESET_VALUE, 0, value loaded by reset
- PRESET_VALUE, all ones, value loaded by preset

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; highest priority
- input_preset  in  1  synchronous preset; below reset, above everything else; not gated by enable
- input_clock_enable  in  1  when low, register, FSM and captured command hold
- input_start  in  1  command request
- input_mode  in  2  00 load, 01 shift left, 10 shift right logical, 11 shift right arithmetic (see Configuration)
- input_amount  in  SHIFT_BITS  shift count
- input_serial  in  1  bit shifted into vacated position for logical shifts
- input_d  in  WIDTH  parallel load data
- output_q  out  WIDTH  register contents
- output_serial  out  1  last bit shifted out
- output_busy  out  1  multi-cycle shift in progress
- output_done  out  1  one-clock completion pulse

## Operation

- Priority per edge: reset > input_preset > (input_clock_enable gated) command/shift.
- reset: output_q=RESET_VALUE, output_serial=0, busy=0, done=0, state IDLE.
- input_preset: output_q=PRESET_VALUE, output_serial=0, busy=0, done=0, IDLE; aborts any shift with no done pulse.
- States: IDLE, SHIFT.
- IDLE, enable=1, start=1: mode, amount, serial captured.
  - Load: q←d.
  - Amount 0: q unchanged.
  - Amount N≥1: first shift performed on the same edge.
  - N≤1 (or load/amount 0): done=1 next cycle, stay IDLE.
  - N≥2: remaining=N−1, busy=1, go SHIFT.
- SHIFT, enable=1: one shift per edge, remaining decrements; on the edge remaining reaches 0: busy←0, done←1, go IDLE.
- start while busy: ignored; command not queued.
- Shift semantics:
  - Left: q←{q[W−2:0],serial}; shifted-out bit = q[W−1].
  - Right logical: q←{serial,q[W−1:1]}; shifted-out bit = q[0].
  - Arithmetic right: MSB replicated; shifted-out bit = q[0].
- output_serial updates on every shift edge; unchanged by load.
- enable=0: q, state, remaining, busy held. done still clears after exactly one clock.

## Timing

- Load latency: 1 edge; q and done valid after the accepting edge.
- Shift by N≥1: N enabled edges; busy high after edges 1..N−1; done high for the clock after edge N.
- done is never asserted on the same cycle as busy.
- done and busy are registered outputs; no combinational path from inputs to outputs.

## Configuration

- SHIFT_REG_ROTATE_EN defined: mode 11 = rotate left; q←{q[W−2:0],q[W−1]}; output_serial = rotated bit; input_serial ignored.
- Not defined: mode 11 = arithmetic right shift.

## Test plan

- Reset, then assert preset, both with enable=0 → q=0x00 after the reset edge, then q=0xFF; busy=0, done=0.
- Load 0xA5 → q=0xA5 after one edge; done high for exactly one cycle; busy never high.
- q=0xA5, shift left by 3, serial=1 → q=0x2F after 3 edges; busy high two cycles; done on the 4th cycle; output_serial=1.
- q=0x84, mode 11 by 2:
  - Macro off → q=0xE1, output_serial=0.
  - Macro on → q=0x12, output_serial=0.
- q=0xF0, shift right logical by 4, serial=0, enable dropped 2 cycles after the first shift → q holds 0x78 and busy holds; q=0x0F, done after 6 edges.
- Mid-shift start with a new load → ignored. Then preset during the shift → q=0xFF, busy=0, no done pulse.
